// File: rtl/voice_scheduler_pkg.sv
// Shared constants and types for the polyphonic voice scheduler.
package voice_scheduler_pkg;

  localparam int SYNTH_PHASE_ACC_BITS = 32;
  localparam int NUM_VOICES_DEF       = 4;
  localparam int NOTE_WIDTH_DEF       = 7;
  localparam int AGE_WIDTH_DEF        = 4;

  typedef struct packed {
    logic                      active;
    logic [NOTE_WIDTH_DEF-1:0] note;
    logic [AGE_WIDTH_DEF-1:0]  age;
  } voice_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } voice_sched_state_t;

  // Increments for notes 120..131 at a 192 kHz DDS rate with a 32-bit
  // accumulator: round(f * 2^32 / 192000). Lower octaves are exact right shifts.
  function automatic logic [31:0] top_octave_incr(input int semi);
    logic [31:0] v;
    case (semi)
      0:       v = 32'd187278874;
      1:       v = 32'd198415039;
      2:       v = 32'd210213420;
      3:       v = 32'd222713348;
      4:       v = 32'd235956587;
      5:       v = 32'd249987332;
      6:       v = 32'd264852406;
      7:       v = 32'd280601248;
      8:       v = 32'd297286672;
      9:       v = 32'd314964268;
      10:      v = 32'd333692936;
      default: v = 32'd353535507;
    endcase
    return v;
  endfunction

  // Full 128-entry note -> increment table, octave by octave.
  function automatic logic [31:0] note_incr_raw(input logic [6:0] note);
    int n;
    int oct;
    int semi;
    n    = int'(note);
    oct  = n / 12;
    semi = n - oct * 12;
    return top_octave_incr(semi) >> (10 - oct);
  endfunction

endpackage

// File: rtl/voice_scheduler_note_to_incr.sv
// Combinational note number to DDS phase increment lookup.
module note_to_incr
  import voice_scheduler_pkg::*;
#(
  parameter int NOTE_WIDTH = 7,
  parameter int INCR_WIDTH = SYNTH_PHASE_ACC_BITS
) (
  input  logic [NOTE_WIDTH-1:0] note,
  output logic [INCR_WIDTH-1:0] incr
);

  logic [NOTE_WIDTH+6:0]  note_ext;
  logic [31:0]            raw;
  logic [INCR_WIDTH+31:0] incr_ext;

  // Table lookup, then zero-extend or truncate to the accumulator width.
  always_comb begin
    note_ext = {7'b0, note};
    raw      = note_incr_raw(note_ext[6:0]);
    incr_ext = {{INCR_WIDTH{1'b0}}, raw};
    incr     = incr_ext[INCR_WIDTH-1:0];
  end

endmodule

// File: rtl/voice_scheduler.sv
// Voice allocator and per-sample slot sequencer feeding the shared DDS datapath.
module voice_scheduler
  import voice_scheduler_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int NOTE_WIDTH = NOTE_WIDTH_DEF,
  parameter int INCR_WIDTH = SYNTH_PHASE_ACC_BITS,
  parameter int AGE_WIDTH  = AGE_WIDTH_DEF
) (
  input  logic                          clk_in,
  input  logic                          n_rst_in,
  input  logic                          evt_valid_in,
  output logic                          evt_ready_out,
  input  logic                          evt_on_in,
  input  logic [NOTE_WIDTH-1:0]         evt_note_in,
  input  logic                          sample_tick_in,
  output logic                          voice_valid_out,
  output logic [$clog2(NUM_VOICES)-1:0] voice_idx_out,
  output logic                          frame_start_out,
  output logic                          voice_gate_out,
  output logic [INCR_WIDTH-1:0]         phase_incr_out,
  output logic [NUM_VOICES-1:0]         active_mask_out,
  output logic                          overrun_out
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic [AGE_WIDTH-1:0] AGE_MAX  = '1;

  voice_sched_state_t state, state_next;

  logic [NUM_VOICES-1:0] active;
  logic [NOTE_WIDTH-1:0] note [NUM_VOICES];
  logic [AGE_WIDTH-1:0]  age  [NUM_VOICES];

  logic             accept;
  logic             hit_any, free_any;
  logic [IDX_W-1:0] hit_idx, free_idx, steal_idx, target_idx;

  logic             load_slot;
  logic [IDX_W-1:0] sel_idx;
  logic [NOTE_WIDTH-1:0] sel_note;
  logic             sel_active;
  logic [INCR_WIDTH-1:0] sel_incr;

  // State register; reset aborts any sweep in progress.
  always_ff @(posedge clk_in or negedge n_rst_in) begin
    if (!n_rst_in) state <= IDLE;
    else           state <= state_next;
  end

  // Next state and event handshake; a tick wins over a same-cycle event.
  always_comb begin
    state_next    = state;
    evt_ready_out = 1'b0;
    unique case (state)
      IDLE: begin
        evt_ready_out = n_rst_in && !sample_tick_in;
        if (sample_tick_in) state_next = SWEEP;
      end
      SWEEP: begin
        if (voice_idx_out == LAST_IDX) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = evt_valid_in && evt_ready_out;

  // Allocator candidates: matching slot, lowest free slot, oldest slot.
  always_comb begin
    hit_any   = 1'b0;
    hit_idx   = '0;
    free_any  = 1'b0;
    free_idx  = '0;
    steal_idx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (active[i] && note[i] == evt_note_in) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!active[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (age[i] > age[steal_idx]) steal_idx = IDX_W'(i);
    end
    target_idx = hit_any ? hit_idx : (free_any ? free_idx : steal_idx);
  end

  // Slot state update on an accepted note-on / note-off.
  always_ff @(posedge clk_in or negedge n_rst_in) begin
    if (!n_rst_in) begin
      active <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note[i] <= '0;
        age[i]  <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (evt_on_in) begin
          if (IDX_W'(i) == target_idx) begin
            active[i] <= 1'b1;
            note[i]   <= evt_note_in;
            age[i]    <= '0;
          end else if (active[i] && age[i] != AGE_MAX) begin
            age[i] <= age[i] + 1'b1;
          end
        end else if (active[i] && note[i] == evt_note_in) begin
          active[i] <= 1'b0;
          age[i]    <= '0;
        end
      end
    end
  end

  assign active_mask_out = active;

  // Slot to present next: slot 0 on the tick, then the following slot.
  assign load_slot  = (state == IDLE && sample_tick_in) ||
                      (state == SWEEP && voice_idx_out != LAST_IDX);
  assign sel_idx    = (state == SWEEP) ? voice_idx_out + 1'b1 : '0;
  assign sel_note   = note[sel_idx];
  assign sel_active = active[sel_idx];

  note_to_incr #(
    .NOTE_WIDTH (NOTE_WIDTH),
    .INCR_WIDTH (INCR_WIDTH)
  ) u_note_to_incr (
    .note (sel_note),
    .incr (sel_incr)
  );

  // Registered sweep outputs and the sticky overrun flag.
  always_ff @(posedge clk_in or negedge n_rst_in) begin
    if (!n_rst_in) begin
      voice_valid_out <= 1'b0;
      voice_idx_out   <= '0;
      frame_start_out <= 1'b0;
      voice_gate_out  <= 1'b0;
      phase_incr_out  <= '0;
      overrun_out     <= 1'b0;
    end else begin
      if (state == SWEEP && sample_tick_in) overrun_out <= 1'b1;
      if (load_slot) begin
        voice_valid_out <= 1'b1;
        voice_idx_out   <= sel_idx;
        frame_start_out <= (state == IDLE);
        voice_gate_out  <= sel_active;
        phase_incr_out  <= sel_active ? sel_incr : '0;
      end else begin
        voice_valid_out <= 1'b0;
        voice_idx_out   <= '0;
        frame_start_out <= 1'b0;
        voice_gate_out  <= 1'b0;
        phase_incr_out  <= '0;
      end
    end
  end

endmodule
